// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the memory stage and a byte-lane data memory.
// Splits word-crossing accesses into two beats and extends load results.
module dmem_lsu_ctrl #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_resp_split,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wr_data,
    output logic [3:0]  o_mem_wr_en,
    input  logic [31:0] i_mem_rd_data
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [63:0] r_buf;
    logic        r_resp_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_split;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wr_data;
    logic [3:0]  r_mem_wr_en;

    logic        w_idle;
    logic        w_we;
    logic [1:0]  w_size;
    logic        w_uns;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_off;
    logic [2:0]  w_nb;
    logic [3:0]  w_mask4;
    logic        w_cross;
    logic        w_bad;
    logic [7:0]  w_mask8;
    logic [63:0] w_shift;
    logic [63:0] w_rbuf;
    logic [31:0] w_rsh;
    logic [31:0] w_ldata;
    logic [31:0] w_result;

    // In IDLE the request ports are decoded directly; afterwards the latched copy.
    assign w_idle  = (r_state == IDLE);
    assign w_we    = w_idle ? i_req_we       : r_we;
    assign w_size  = w_idle ? i_req_size     : r_size;
    assign w_uns   = w_idle ? i_req_unsigned : r_uns;
    assign w_addr  = w_idle ? i_req_addr     : r_addr;
    assign w_wdata = w_idle ? i_req_wdata    : r_wdata;
    assign w_off   = w_addr[1:0];

    always_comb begin
        w_nb    = 3'd0;
        w_mask4 = 4'b0000;
        unique case (w_size)
            2'b00:   begin w_nb = 3'd1; w_mask4 = 4'b0001; end
            2'b01:   begin w_nb = 3'd2; w_mask4 = 4'b0011; end
            2'b10:   begin w_nb = 3'd4; w_mask4 = 4'b1111; end
            default: begin w_nb = 3'd0; w_mask4 = 4'b0000; end
        endcase
    end

    assign w_cross = ({1'b0, w_off} + w_nb) > 3'd4;
    assign w_bad   = (w_size == 2'b11) || (w_cross && !ALLOW_MISALIGNED);
    assign w_mask8 = {4'b0000, w_mask4} << w_off;
    assign w_shift = {32'd0, w_wdata} << {w_off, 3'b000};

    // Merge the beat being read this cycle with what was already buffered.
    assign w_rbuf = (r_state == BEAT0) ? {r_buf[63:32], i_mem_rd_data}
                                       : {i_mem_rd_data, r_buf[31:0]};
    assign w_rsh  = 32'(w_rbuf >> {w_off, 3'b000});

    always_comb begin
        w_ldata = w_rsh;
        unique case (w_size)
            2'b00:   w_ldata = {{24{!w_uns && w_rsh[7]}}, w_rsh[7:0]};
            2'b01:   w_ldata = {{16{!w_uns && w_rsh[15]}}, w_rsh[15:0]};
            default: w_ldata = w_rsh;
        endcase
    end

    assign w_result = w_we ? 32'd0 : w_ldata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_size        <= 2'b00;
            r_uns         <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_buf         <= 64'd0;
            r_resp_valid  <= 1'b0;
            r_rdata       <= 32'd0;
            r_err         <= 1'b0;
            r_split       <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_mem_wr_data <= 32'd0;
            r_mem_wr_en   <= 4'b0000;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_we    <= i_req_we;
                        r_size  <= i_req_size;
                        r_uns   <= i_req_unsigned;
                        r_addr  <= i_req_addr;
                        r_wdata <= i_req_wdata;
                        r_split <= 1'b0;
                        r_rdata <= 32'd0;
                        r_err   <= w_bad;
                        if (w_bad) begin
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_state    <= BEAT0;
                            r_mem_addr <= {i_req_addr[31:2], 2'b00};
                            if (i_req_we) begin
                                r_mem_wr_en   <= w_mask8[3:0];
                                r_mem_wr_data <= w_shift[31:0];
                            end
                        end
                    end
                end
                BEAT0: begin
                    r_buf[31:0] <= i_mem_rd_data;
                    r_mem_wr_en   <= (w_cross && r_we) ? w_mask8[7:4] : 4'b0000;
                    r_mem_wr_data <= (w_cross && r_we) ? w_shift[63:32] : 32'd0;
                    if (w_cross) begin
                        r_state    <= BEAT1;
                        r_mem_addr <= r_mem_addr + 32'd4;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_rdata      <= w_result;
                    end
                end
                BEAT1: begin
                    r_buf[63:32]  <= i_mem_rd_data;
                    r_mem_wr_en   <= 4'b0000;
                    r_mem_wr_data <= 32'd0;
                    r_state       <= RESP;
                    r_resp_valid  <= 1'b1;
                    r_split       <= 1'b1;
                    r_rdata       <= w_result;
                end
                RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
            endcase
        end
    end

    assign o_req_ready   = w_idle && !i_rst;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_rdata  = r_rdata;
    assign o_resp_err    = r_err;
    assign o_resp_split  = r_split;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wr_data = r_mem_wr_data;
    assign o_mem_wr_en   = r_mem_wr_en;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: byte-array reference model, directed and random requests.
// Two instances cover ALLOW_MISALIGNED = 1 (sel=0) and 0 (sel=1).
module tb_dmem_lsu_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, minit, valid, we, uns, resp_ready, sel;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        rdy1, rv1, err1, sp1, rdy0, rv0, err0, sp0;
    logic [31:0] rd1, ma1, wd1, mrd1, rd0, ma0, wd0, mrd0;
    logic [3:0]  en1, en0;

    logic        o_rdy, o_rv, o_err, o_sp;
    logic [31:0] o_rd, o_ma, o_wd;
    logic [3:0]  o_en;

    logic [31:0] dmem [256];
    logic [7:0]  refm [1024];
    logic [31:0] ob_addr [3];
    logic [31:0] ob_data [3];
    logic [3:0]  ob_en [3];

    int total = 0;
    int bad = 0;

    dmem_lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid && !sel),
        .o_req_ready(rdy1), .i_req_we(we), .i_req_size(size),
        .i_req_unsigned(uns), .i_req_addr(addr), .i_req_wdata(wdata),
        .o_resp_valid(rv1), .i_resp_ready(resp_ready),
        .o_resp_rdata(rd1), .o_resp_err(err1), .o_resp_split(sp1),
        .o_mem_addr(ma1), .o_mem_wr_data(wd1), .o_mem_wr_en(en1),
        .i_mem_rd_data(mrd1)
    );

    dmem_lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid && sel),
        .o_req_ready(rdy0), .i_req_we(we), .i_req_size(size),
        .i_req_unsigned(uns), .i_req_addr(addr), .i_req_wdata(wdata),
        .o_resp_valid(rv0), .i_resp_ready(resp_ready),
        .o_resp_rdata(rd0), .o_resp_err(err0), .o_resp_split(sp0),
        .o_mem_addr(ma0), .o_mem_wr_data(wd0), .o_mem_wr_en(en0),
        .i_mem_rd_data(mrd0)
    );

    function automatic logic [7:0] pat(int k);
        return 8'(k * 37 + 5);
    endfunction

    // Only the ALLOW_MISALIGNED=1 instance writes memory; the other only reads.
    always @(posedge clk) begin
        if (minit) begin
            for (int i = 0; i < 256; i++)
                dmem[i] <= {pat(4*i+3), pat(4*i+2), pat(4*i+1), pat(4*i)};
        end else begin
            for (int j = 0; j < 4; j++)
                if (en1[j]) dmem[ma1[9:2]][8*j +: 8] <= wd1[8*j +: 8];
        end
    end

    assign mrd1  = dmem[ma1[9:2]];
    assign mrd0  = dmem[ma0[9:2]];
    assign o_rdy = sel ? rdy0 : rdy1;
    assign o_rv  = sel ? rv0  : rv1;
    assign o_err = sel ? err0 : err1;
    assign o_sp  = sel ? sp0  : sp1;
    assign o_rd  = sel ? rd0  : rd1;
    assign o_ma  = sel ? ma0  : ma1;
    assign o_wd  = sel ? wd0  : wd1;
    assign o_en  = sel ? en0  : en1;

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] a, logic [1:0] sz, logic u);
        logic [31:0] v, t;
        int nb;
        v = 32'd0;
        nb = nbytes(sz);
        for (int i = 0; i < nb; i++) begin
            t = a + 32'(i);
            v[8*i +: 8] = refm[t[9:0]];
        end
        if (!u && nb > 0 && nb < 4 && v[8*nb-1])
            for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] t;
        for (int i = 0; i < nbytes(sz); i++) begin
            t = a + 32'(i);
            refm[t[9:0]] = d[8*i +: 8];
        end
    endtask

    // Present one request and follow it until resp_valid; the response stays pending.
    task automatic run_req(input logic s, input logic w, input logic [1:0] sz,
                           input logic u, input logic [31:0] a, input logic [31:0] d,
                           output int lat);
        int n;
        @(negedge clk);
        sel = s; we = w; size = sz; uns = u; addr = a; wdata = d;
        valid = 1'b1; resp_ready = 1'b0;
        n = 0;
        while (!o_rdy && n < 20) begin @(negedge clk); n++; end
        if (!o_rdy) begin
            total++; bad++;
            $display("FAIL accept_timeout addr=%h ready=%b want 1", a, o_rdy);
            valid = 1'b0; lat = -1;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            ob_addr[k] = 32'd0; ob_data[k] = 32'd0; ob_en[k] = 4'd0;
        end
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            valid = 1'b0;
            lat++;
            if (lat <= 3) begin
                ob_addr[lat-1] = o_ma; ob_data[lat-1] = o_wd; ob_en[lat-1] = o_en;
            end
            if (o_rv) break;
        end
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; minit = 1'b1; valid = 1'b0; resp_ready = 1'b0; sel = 1'b0;
        we = 1'b0; size = 2'd0; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 1024; i++) refm[i] = pat(i);
        @(negedge clk);
        minit = 1'b0;
        @(negedge clk);
        total++;
        if ({rdy1, rv1, en1, rdy0, rv0, en0} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want 0", {rdy1, rv1, en1, rdy0, rv0, en0});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rdy1 !== 1'b1 || rv1 !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_ready rdy=%b rv=%b want 1 0", rdy1, rv1);
        end
    endtask

    task automatic test_word();
        int lat;
        run_req(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, lat);
        total++;
        if (lat !== 2 || ob_addr[0] !== 32'h100 || ob_en[0] !== 4'b1111 ||
            ob_data[0] !== 32'hDEADBEEF || o_rd !== 32'd0 || o_sp !== 1'b0) begin
            bad++;
            $display("FAIL word_store lat=%0d a=%h en=%b d=%h rd=%h want 2 100 1111 deadbeef 0",
                     lat, ob_addr[0], ob_en[0], ob_data[0], o_rd);
        end
        ack();
        ref_store(32'h100, 2'd2, 32'hDEADBEEF);
        run_req(0, 0, 2'd2, 0, 32'h100, 32'h0, lat);
        total++;
        if (lat !== 2 || o_rd !== 32'hDEADBEEF || o_sp !== 1'b0 || ob_en[0] !== 4'd0) begin
            bad++;
            $display("FAIL word_load lat=%0d rd=%h split=%b want 2 deadbeef 0", lat, o_rd, o_sp);
        end
        ack();
    endtask

    task automatic test_lanes();
        int lat;
        run_req(0, 1, 2'd0, 0, 32'h203, 32'h000000A5, lat);
        total++;
        if (ob_en[0] !== 4'b1000 || ob_data[0] !== 32'hA5000000 || lat !== 2) begin
            bad++;
            $display("FAIL byte_store en=%b d=%h lat=%0d want 1000 a5000000 2",
                     ob_en[0], ob_data[0], lat);
        end
        ack();
        ref_store(32'h203, 2'd0, 32'hA5);
        run_req(0, 0, 2'd0, 0, 32'h203, 32'h0, lat);
        total++;
        if (o_rd !== 32'hFFFFFFA5) begin
            bad++; $display("FAIL byte_load_s got=%h want ffffffa5", o_rd);
        end
        ack();
        run_req(0, 0, 2'd0, 1, 32'h203, 32'h0, lat);
        total++;
        if (o_rd !== 32'h000000A5) begin
            bad++; $display("FAIL byte_load_u got=%h want 000000a5", o_rd);
        end
        ack();
        run_req(0, 1, 2'd1, 0, 32'h202, 32'h00008001, lat);
        total++;
        if (ob_en[0] !== 4'b1100 || ob_data[0][31:16] !== 16'h8001) begin
            bad++;
            $display("FAIL half_store en=%b d=%h want 1100 8001xxxx", ob_en[0], ob_data[0]);
        end
        ack();
        ref_store(32'h202, 2'd1, 32'h8001);
        run_req(0, 0, 2'd1, 0, 32'h202, 32'h0, lat);
        total++;
        if (o_rd !== 32'hFFFF8001) begin
            bad++; $display("FAIL half_load_s got=%h want ffff8001", o_rd);
        end
        ack();
    endtask

    task automatic test_split();
        int lat;
        run_req(0, 1, 2'd2, 0, 32'h302, 32'h11223344, lat);
        total++;
        if (ob_addr[0] !== 32'h300 || ob_en[0] !== 4'b1100 || ob_data[0] !== 32'h33440000) begin
            bad++;
            $display("FAIL split_beat0 a=%h en=%b d=%h want 300 1100 33440000",
                     ob_addr[0], ob_en[0], ob_data[0]);
        end
        total++;
        if (ob_addr[1] !== 32'h304 || ob_en[1] !== 4'b0011 || ob_data[1] !== 32'h00001122 ||
            ob_en[2] !== 4'd0 || lat !== 3) begin
            bad++;
            $display("FAIL split_beat1 a=%h en=%b d=%h lat=%0d want 304 0011 00001122 3",
                     ob_addr[1], ob_en[1], ob_data[1], lat);
        end
        ack();
        ref_store(32'h302, 2'd2, 32'h11223344);
        run_req(0, 0, 2'd2, 0, 32'h302, 32'h0, lat);
        total++;
        if (o_rd !== 32'h11223344 || o_sp !== 1'b1 || lat !== 3) begin
            bad++;
            $display("FAIL split_load rd=%h split=%b lat=%0d want 11223344 1 3", o_rd, o_sp, lat);
        end
        ack();
    endtask

    task automatic test_errors();
        int lat;
        run_req(1, 0, 2'd2, 0, 32'h301, 32'h0, lat);
        total++;
        if (o_err !== 1'b1 || o_rd !== 32'd0 || o_sp !== 1'b0 || lat !== 1 || ob_en[0] !== 4'd0) begin
            bad++;
            $display("FAIL misalign_reject err=%b rd=%h lat=%0d en=%b want 1 0 1 0000",
                     o_err, o_rd, lat, ob_en[0]);
        end
        ack();
        run_req(1, 0, 2'd1, 1, 32'h301, 32'h0, lat);
        total++;
        if (o_err !== 1'b0 || o_rd !== ref_load(32'h301, 2'd1, 1'b1) || lat !== 2) begin
            bad++;
            $display("FAIL inword_half_noerr err=%b rd=%h lat=%0d want 0 %h 2",
                     o_err, o_rd, lat, ref_load(32'h301, 2'd1, 1'b1));
        end
        ack();
        for (int s = 0; s < 2; s++) begin
            run_req(s[0], 1, 2'd3, 0, 32'h40, 32'hFFFFFFFF, lat);
            total++;
            if (o_err !== 1'b1 || o_rd !== 32'd0 || lat !== 1 || ob_en[0] !== 4'd0) begin
                bad++;
                $display("FAIL illegal_size sel=%0d err=%b rd=%h lat=%0d en=%b want 1 0 1 0000",
                         s, o_err, o_rd, lat, ob_en[0]);
            end
            ack();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] exp;
        exp = ref_load(32'h302, 2'd2, 1'b0);
        run_req(0, 0, 2'd2, 0, 32'h302, 32'h0, lat);
        sel = 1'b0; we = 1'b1; size = 2'd0; addr = 32'h10; wdata = 32'h0000005A;
        valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (o_rv !== 1'b1 || o_rd !== exp || o_sp !== 1'b1 || o_rdy !== 1'b0 || o_en !== 4'd0) begin
                bad++;
                $display("FAIL hold_resp c=%0d rv=%b rd=%h rdy=%b en=%b want 1 %h 0 0000",
                         c, o_rv, o_rd, o_rdy, o_en, exp);
            end
        end
        ack();
        total++;
        if (o_rv !== 1'b0 || o_rdy !== 1'b1) begin
            bad++;
            $display("FAIL after_handshake rv=%b rdy=%b want 0 1", o_rv, o_rdy);
        end
        @(negedge clk);
        valid = 1'b0;
        total++;
        if (o_en !== 4'b0001 || o_wd[7:0] !== 8'h5A || o_ma !== 32'h10) begin
            bad++;
            $display("FAIL second_req_beat0 en=%b d=%h a=%h want 0001 xx5a 10", o_en, o_wd, o_ma);
        end
        @(negedge clk);
        total++;
        if (o_rv !== 1'b1 || o_err !== 1'b0) begin
            bad++; $display("FAIL second_req_resp rv=%b err=%b want 1 0", o_rv, o_err);
        end
        ack();
        ref_store(32'h10, 2'd0, 32'h5A);
    endtask

    task automatic test_reset_wrap();
        int lat;
        @(negedge clk);
        sel = 1'b0; we = 1'b1; size = 2'd2; uns = 1'b0;
        addr = 32'h3FE; wdata = 32'hAABBCCDD; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        total++;
        if (o_ma !== 32'h3FC || o_en !== 4'b1100) begin
            bad++; $display("FAIL rst_beat0 a=%h en=%b want 3fc 1100", o_ma, o_en);
        end
        @(negedge clk);
        total++;
        if (o_ma !== 32'h400 || o_en !== 4'b0011) begin
            bad++; $display("FAIL rst_beat1 a=%h en=%b want 400 0011", o_ma, o_en);
        end
        rst = 1'b1;
        #1;
        total++;
        if (o_rdy !== 1'b0 || o_en !== 4'd0 || o_rv !== 1'b0) begin
            bad++; $display("FAIL rst_midop rdy=%b en=%b rv=%b want 0 0000 0", o_rdy, o_en, o_rv);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_store(32'h3FE, 2'd1, 32'hCCDD);
        run_req(0, 0, 2'd2, 0, 32'h3FC, 32'h0, lat);
        total++;
        if (o_rd !== ref_load(32'h3FC, 2'd2, 1'b0) || lat !== 2) begin
            bad++; $display("FAIL rst_beat0_kept rd=%h want %h", o_rd, ref_load(32'h3FC, 2'd2, 1'b0));
        end
        ack();
        run_req(0, 0, 2'd2, 0, 32'h400, 32'h0, lat);
        total++;
        if (o_rd !== ref_load(32'h400, 2'd2, 1'b0)) begin
            bad++; $display("FAIL rst_no_beat1 rd=%h want %h", o_rd, ref_load(32'h400, 2'd2, 1'b0));
        end
        ack();
        run_req(0, 1, 2'd2, 0, 32'hFFFFFFFE, 32'h01020304, lat);
        total++;
        if (ob_addr[0] !== 32'hFFFFFFFC || ob_addr[1] !== 32'h0 || ob_en[1] !== 4'b0011 || lat !== 3) begin
            bad++;
            $display("FAIL wrap_addr a0=%h a1=%h en1=%b lat=%0d want fffffffc 0 0011 3",
                     ob_addr[0], ob_addr[1], ob_en[1], lat);
        end
        ack();
        ref_store(32'hFFFFFFFE, 2'd2, 32'h01020304);
        run_req(0, 0, 2'd2, 0, 32'hFFFFFFFE, 32'h0, lat);
        total++;
        if (o_rd !== 32'h01020304 || o_sp !== 1'b1) begin
            bad++; $display("FAIL wrap_load rd=%h split=%b want 01020304 1", o_rd, o_sp);
        end
        ack();
    endtask

    task automatic test_random();
        int lat, nb, off, elat;
        logic s, w, u, e_err, e_split;
        logic [1:0] sz;
        logic [31:0] a, d, e_rd, wa, ba, dl;
        logic [3:0] e_en;
        for (int it = 0; it < 80; it++) begin
            s = ($urandom_range(0, 4) == 0);
            w = $urandom_range(0, 1) == 1;
            u = $urandom_range(0, 1) == 1;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom;
            d = $urandom;
            if (s) w = 1'b0;
            nb = nbytes(sz);
            off = int'(a[1:0]);
            e_err = (sz == 2'd3) || (s && off + nb > 4);
            e_split = !e_err && (off + nb > 4);
            elat = e_err ? 1 : (e_split ? 3 : 2);
            e_rd = (w || e_err) ? 32'd0 : ref_load(a, sz, u);
            run_req(s, w, sz, u, a, d, lat);
            total++;
            if (o_err !== e_err || o_sp !== e_split || lat !== elat || o_rd !== e_rd) begin
                bad++;
                $display("FAIL rand_resp it=%0d a=%h sz=%0d got err=%b sp=%b lat=%0d rd=%h want %b %b %0d %h",
                         it, a, sz, o_err, o_sp, lat, o_rd, e_err, e_split, elat, e_rd);
            end
            wa = {a[31:2], 2'b00};
            for (int k = 0; k < 2; k++) begin
                if (k == 0 || e_split) begin
                    e_en = 4'd0;
                    for (int j = 0; j < 4; j++) begin
                        ba = wa + 32'(4*k + j);
                        dl = ba - a;
                        e_en[j] = w && !e_err && (dl < 32'(nb));
                    end
                    total++;
                    if (ob_en[k] !== e_en || (!e_err && ob_addr[k] !== wa + 32'(4*k))) begin
                        bad++;
                        $display("FAIL rand_beat it=%0d k=%0d en=%b a=%h want %b %h",
                                 it, k, ob_en[k], ob_addr[k], e_en, wa + 32'(4*k));
                    end
                    for (int j = 0; j < 4; j++) begin
                        dl = wa + 32'(4*k + j) - a;
                        if (e_en[j]) begin
                            total++;
                            if (ob_data[k][8*j +: 8] !== d[8*dl[1:0] +: 8]) begin
                                bad++;
                                $display("FAIL rand_lane it=%0d k=%0d j=%0d got=%h want %h",
                                         it, k, j, ob_data[k][8*j +: 8], d[8*dl[1:0] +: 8]);
                            end
                        end
                    end
                end
            end
            ack();
            if (w && !e_err) ref_store(a, sz, d);
        end
    endtask

    task automatic test_memory_image();
        int mism;
        mism = 0;
        for (int i = 0; i < 1024; i++)
            if (dmem[i/4][8*(i%4) +: 8] !== refm[i]) mism++;
        total++;
        if (mism != 0) begin
            bad++; $display("FAIL memory_image mismatched_bytes=%0d want 0", mism);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_split();
        test_errors();
        test_backpressure();
        test_reset_wrap();
        test_random();
        test_memory_image();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
